// File: rtl/commit_trace_fifo.sv
// Commit trace recorder: packs each cycle's register/memory events into one timestamped FIFO entry.
// Latency: 1 cycle from event to out_valid. Backpressure: never stalls the core; drops are counted when full.
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic                     out_reg_v,
    output logic [4:0]               out_reg_num,
    output logic [31:0]              out_reg_data,
    output logic [1:0]               out_mem_kind,
    output logic [8:0]               out_mem_addr,
    output logic [31:0]              out_mem_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic            reg_v;
        logic [4:0]      reg_num;
        logic [31:0]     reg_data;
        logic [1:0]      mem_kind;
        logic [8:0]      mem_addr;
        logic [31:0]     mem_data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_e;
    entry_t          head;
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [AW:0]     count_nxt;
    logic [TS_W-1:0] ts;
    logic            ev;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    always_comb begin
        in_e          = '0;
        in_e.ts       = ts;
        in_e.reg_v    = reg_write_sig;
        if (reg_write_sig) begin
            in_e.reg_num  = reg_num;
            in_e.reg_data = reg_data;
        end
        // {wr, rd} is already the kind encoding, including 11 for a conflict
        in_e.mem_kind = {wr, rd};
        if (wr | rd) in_e.mem_addr = addr;
        if (wr)      in_e.mem_data = wr_data;
        else if (rd) in_e.mem_data = rd_data;
    end

    assign ev   = reg_write_sig | wr | rd;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop  = out_valid & out_ready;
    // A pop on a full FIFO frees the head slot at the same edge the tail reuses it
    assign push = ev & (~full | pop);
    assign drop = ev & full & ~pop;

    always_comb begin
        count_nxt = count;
        if (push & ~pop)      count_nxt = count + PTR_ONE;
        else if (pop & ~push) count_nxt = count - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr       <= '0;
            rptr       <= '0;
            ts         <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) begin
                mem[wptr[AW-1:0]] <= in_e;
                wptr              <= wptr + PTR_ONE;
            end
            if (pop) rptr <= rptr + PTR_ONE;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign head         = mem[rptr[AW-1:0]];
    assign out_ts       = head.ts;
    assign out_reg_v    = head.reg_v;
    assign out_reg_num  = head.reg_num;
    assign out_reg_data = head.reg_data;
    assign out_mem_kind = head.mem_kind;
    assign out_mem_addr = head.mem_addr;
    assign out_mem_data = head.mem_data;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: scoreboard of expected entries checked at every pop, plus scenario checks.
module tb_commit_trace_fifo;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;

    logic        clk;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ts;
    logic        out_reg_v;
    logic [4:0]  out_reg_num;
    logic [31:0] out_reg_data;
    logic [1:0]  out_mem_kind;
    logic [8:0]  out_mem_addr;
    logic [31:0] out_mem_data;
    logic [4:0]  count;
    logic [15:0] drop_count;
    logic        overflow;

    commit_trace_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_reg_v(out_reg_v), .out_reg_num(out_reg_num), .out_reg_data(out_reg_data),
        .out_mem_kind(out_mem_kind), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
        .count(count), .drop_count(drop_count), .overflow(overflow)
    );

    typedef struct packed {
        logic [15:0] ts;
        logic        reg_v;
        logic [4:0]  reg_num;
        logic [31:0] reg_data;
        logic [1:0]  mem_kind;
        logic [8:0]  mem_addr;
        logic [31:0] mem_data;
    } exp_t;

    exp_t        sb[$];
    int          mcount;
    int          model_ts;
    int          n_checks;
    int          n_pass;
    exp_t        got;
    exp_t        want;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the head against the scoreboard on every cycle that will pop
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got = {out_ts, out_reg_v, out_reg_num, out_reg_data, out_mem_kind, out_mem_addr, out_mem_data};
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL pop_unexpected got %h required no entry", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) $display("FAIL pop_entry got %h required %h", got, want);
                else n_pass++;
            end
        end
    end

    task automatic cycle(input logic rw, input logic [4:0] rn, input logic [31:0] rdt,
                         input logic w, input logic r, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] rdd, input logic rdy);
        exp_t e;
        logic ev, pop, push;
        reg_write_sig = rw; reg_num = rn; reg_data = rdt;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
        out_ready = rdy;
        ev   = rw | w | r;
        pop  = (mcount > 0) && rdy;
        push = ev && ((mcount < DEPTH) || pop);
        e = '0;
        e.ts       = model_ts[15:0];
        e.reg_v    = rw;
        e.reg_num  = rw ? rn : 5'd0;
        e.reg_data = rw ? rdt : 32'd0;
        if (w && r)  begin e.mem_kind = 2'b11; e.mem_data = wd;  e.mem_addr = a; end
        else if (w)  begin e.mem_kind = 2'b10; e.mem_data = wd;  e.mem_addr = a; end
        else if (r)  begin e.mem_kind = 2'b01; e.mem_data = rdd; e.mem_addr = a; end
        if (push) sb.push_back(e);
        mcount = mcount + int'(push) - int'(pop);
        @(posedge clk); #1;
        model_ts++;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic ev_rand(input logic rdy);
        logic [2:0] s;
        s = 3'($urandom_range(1, 7));
        cycle(s[0], 5'($urandom), $urandom, s[1], s[2], 9'($urandom), $urandom, $urandom, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b0;
        reg_write_sig = 1'b1; wr = 1'b1; rd = 1'b0; reg_num = 5'd1; reg_data = 32'h1;
        addr = 9'd1; wr_data = 32'h1; rd_data = 32'h1;
        repeat (2) begin @(posedge clk); #1; end
        sb.delete(); mcount = 0; model_ts = 0;
        reset = 1'b0;
        reg_write_sig = 1'b0; wr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mcount > 0; i++) idle(1'b1);
        n_checks++;
        if (count !== 5'd0 || sb.size() != 0) $display("FAIL drain count %0d queued %0d required 0", count, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b required 0", out_valid); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL rst_count got %0d required 0", count); else n_pass++;
        n_checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop got %0d required 0", drop_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b required 0", overflow); else n_pass++;
        n_checks++;
        if ({out_ts, out_reg_v, out_reg_num, out_reg_data, out_mem_kind, out_mem_addr, out_mem_data} !== 97'd0)
            $display("FAIL rst_data got %h required 0", {out_ts, out_reg_v, out_reg_num, out_reg_data, out_mem_kind, out_mem_addr, out_mem_data});
        else n_pass++;
    endtask

    task automatic test_single();
        cycle(1'b1, 5'd5, 32'hFFFFFFF6, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b required 1", out_valid); else n_pass++;
        n_checks++; if (out_ts !== 16'd0) $display("FAIL single_ts got %0d required 0", out_ts); else n_pass++;
        n_checks++;
        if (out_reg_v !== 1'b1 || out_reg_num !== 5'd5 || out_reg_data !== 32'hFFFFFFF6 || out_mem_kind !== 2'b00)
            $display("FAIL single_fields got v=%b n=%0d d=%h k=%b required v=1 n=5 d=fffffff6 k=00",
                     out_reg_v, out_reg_num, out_reg_data, out_mem_kind);
        else n_pass++;
        idle(1'b1);
    endtask

    task automatic test_combined();
        cycle(1'b1, 5'd3, 32'd7, 1'b1, 1'b0, 9'h104, 32'd42, 32'd0, 1'b1);
        n_checks++; if (count !== 5'd1) $display("FAIL comb_count got %0d required 1", count); else n_pass++;
        n_checks++;
        if (out_reg_v !== 1'b1 || out_reg_num !== 5'd3 || out_reg_data !== 32'd7 || out_mem_kind !== 2'b10 ||
            out_mem_addr !== 9'h104 || out_mem_data !== 32'd42)
            $display("FAIL comb_fields got v=%b n=%0d d=%0d k=%b a=%h m=%0d required v=1 n=3 d=7 k=10 a=104 m=42",
                     out_reg_v, out_reg_num, out_reg_data, out_mem_kind, out_mem_addr, out_mem_data);
        else n_pass++;
        idle(1'b1);
        n_checks++; if (count !== 5'd0) $display("FAIL comb_single_entry count got %0d required 0", count); else n_pass++;
    endtask

    task automatic test_read_conflict();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 9'd8, 32'd0, 32'd99, 1'b1);
        n_checks++;
        if (out_mem_kind !== 2'b01 || out_mem_data !== 32'd99 || out_mem_addr !== 9'd8 || out_reg_v !== 1'b0)
            $display("FAIL read_fields got k=%b m=%0d a=%0d v=%b required k=01 m=99 a=8 v=0",
                     out_mem_kind, out_mem_data, out_mem_addr, out_reg_v);
        else n_pass++;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 9'd8, 32'd3, 32'd77, 1'b1);
        n_checks++;
        if (out_mem_kind !== 2'b11 || out_mem_data !== 32'd3)
            $display("FAIL conflict_fields got k=%b m=%0d required k=11 m=3", out_mem_kind, out_mem_data);
        else n_pass++;
        idle(1'b1);
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (20) ev_rand(1'b0);
        n_checks++; if (count !== 5'd16) $display("FAIL ovf_count got %0d required 16", count); else n_pass++;
        n_checks++; if (drop_count !== 16'd4) $display("FAIL ovf_drop got %0d required 4", drop_count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b required 1", overflow); else n_pass++;
        n_checks++; if (out_ts !== 16'd0) $display("FAIL ovf_head_ts got %0d required 0", out_ts); else n_pass++;
        drain();
        n_checks++; if (overflow !== 1'b1 || drop_count !== 16'd4)
            $display("FAIL ovf_sticky got ovf=%b drop=%0d required ovf=1 drop=4", overflow, drop_count);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        repeat (16) ev_rand(1'b0);
        n_checks++; if (count !== 5'd16) $display("FAIL fullpop_fill got %0d required 16", count); else n_pass++;
        ev_rand(1'b1);
        n_checks++; if (count !== 5'd16) $display("FAIL fullpop_count got %0d required 16", count); else n_pass++;
        n_checks++; if (drop_count !== 16'd4) $display("FAIL fullpop_drop got %0d required 4", drop_count); else n_pass++;
        drain();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            repeat (10) ev_rand(1'b0);
            n_checks++; if (count !== 5'd10) $display("FAIL wrap_fill pass %0d got %0d required 10", p, count); else n_pass++;
            repeat (10) idle(1'b1);
            n_checks++; if (count !== 5'd0) $display("FAIL wrap_empty pass %0d got %0d required 0", p, count); else n_pass++;
        end
        repeat (5) ev_rand(1'b0);
        reset = 1'b1; out_ready = 1'b0; reg_write_sig = 1'b1;
        @(posedge clk); #1;
        sb.delete(); mcount = 0; model_ts = 0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b required 0", out_valid); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL midrst_count got %0d required 0", count); else n_pass++;
        reset = 1'b0;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 9'd3, 32'd11, 32'd0, 1'b0);
        n_checks++; if (out_ts !== 16'd0 || count !== 5'd1)
            $display("FAIL midrst_ts got ts=%0d count=%0d required ts=0 count=1", out_ts, count);
        else n_pass++;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; mcount = 0; model_ts = 0;
        reset = 1'b1; out_ready = 1'b0;
        reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
        wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
        test_reset();
        test_single();
        test_combined();
        test_read_conflict();
        test_overflow();
        test_full_pop();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Synthesizable trace recorder that sits directly downstream of the `riscv` core's observation ports and consumes its register-write and data-memory events. Each cycle with at least one event is packed into one timestamped entry and buffered in a FIFO, so a bench monitor, UART dumper or scoreboard can drain commits with a valid/ready handshake instead of sampling the core every clock. Overflow is counted, never stalls the core.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TS_W`, 16: timestamp width, in bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `reg_write_sig` in 1: core register-write event this cycle.
- `reg_num` in 5: destination register.
- `reg_data` in 32: value written.
- `wr` in 1: data-memory write strobe.
- `rd` in 1: data-memory read strobe.
- `addr` in 9: data-memory address.
- `wr_data` in 32: store data.
- `rd_data` in 32: load data, valid in the same cycle as `rd`.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head.
- `out_ts` out TS_W: cycle stamp of the entry.
- `out_reg_v` out 1: entry contains a register write.
- `out_reg_num` out 5, `out_reg_data` out 32: register-write fields.
- `out_mem_kind` out 2: 00 none, 01 read, 10 write, 11 conflict (`wr` and `rd` both high).
- `out_mem_addr` out 9, `out_mem_data` out 32: memory fields.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `drop_count` out 16: entries lost to overflow; saturates at 0xFFFF.
- `overflow` out 1: sticky, set on the first drop.

## Operation
- Timestamp counter `ts`:
  - Cleared by reset.
  - Increments by 1 every cycle while `reset`=0.
  - Wraps modulo 2^TS_W with no flag.
- Event this cycle: `ev = reg_write_sig | wr | rd`. Cycles with `ev`=0 are not recorded.
- Entry packing, all fields sampled at the capture edge:
  - Register fields: `reg_v=reg_write_sig`. `reg_num`/`reg_data` are forced to 0 when `reg_write_sig`=0.
  - `mem_kind`: 01 for `rd&~wr`, 10 for `wr&~rd`, 11 for `wr&rd`, 00 otherwise.
  - `mem_data`: `rd_data` for 01, `wr_data` for 10 and 11, 0 for 00.
  - `mem_addr`: `addr` when `mem_kind`≠00, else 0.
  - `ts`: value of `ts` before the increment.
- Push condition: `ev & (count<DEPTH | pop)`, where `pop = out_valid & out_ready`.
- When full, a simultaneous pop frees the slot in the same cycle. The push succeeds and `count` is unchanged.
- Drop: `ev & full & ~pop`.
  - `drop_count` increments, saturating.
  - `overflow` is set and stays set until reset.
  - FIFO contents are unchanged.
- Pop: the head advances. The out_* fields are the head entry (registered storage, not a combinational bypass of the inputs).
- Storage is circular. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap naturally.
- When `out_valid`=0, out_* data is don't-care but must be stable (no X after reset). Zero-initialise storage on reset.

## Timing
- Reset values:
  - `out_valid`=0, `count`=0, `drop_count`=0, `overflow`=0, `ts`=0.
  - All out_* data fields 0.
- Reset held mid-operation empties the FIFO on that edge. Events presented while `reset`=1 are ignored.
- Latency: an event presented in cycle N is written at edge N. `out_valid`=1 and its fields appear in cycle N+1. Minimum latency is 1 cycle.
- `count`:
  - Updates at the same edge as the push/pop.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop on empty is impossible, because pop requires `out_valid`.
- `out_valid == (count != 0)`, registered.
- Throughput: 1 entry per cycle in and 1 entry per cycle out.
- Head fields are stable while `out_valid & ~out_ready`.
- The first event after reset, in the cycle following deassertion, carries `ts`=0.

## Test plan
- **Single register write:** release reset; next cycle drive `reg_write_sig`=1, `reg_num`=5, `reg_data`=0xFFFFFFF6; keep `out_ready`=1.
  - Next cycle: `out_valid`=1, `out_ts`=0, `out_reg_v`=1, `out_reg_num`=5, `out_reg_data`=0xFFFFFFF6, `out_mem_kind`=00.
- **Combined register write and store:** same cycle `reg_write_sig`=1 (x3=7) and `wr`=1, `addr`=0x104, `wr_data`=42.
  - Exactly one entry with `reg_v`=1, `mem_kind`=10, `mem_addr`=0x104, `mem_data`=42.
- **Read and conflict:**
  - `rd`=1, `addr`=8, `rd_data`=99 → `mem_kind`=01, `mem_data`=99.
  - `rd`=`wr`=1, `wr_data`=3 → `mem_kind`=11, `mem_data`=3.
- **Overflow:** with `out_ready`=0, DEPTH=16, present 20 consecutive events.
  - Result: `count`=16, `drop_count`=4, `overflow`=1.
  - Drain: the 16 entries come out in order with `ts` 0..15.
- **Full with simultaneous pop:** fill to 16; then one cycle with `ev`=1 and `out_ready`=1.
  - Result: `count` stays 16, `drop_count` unchanged, new entry at tail.
- **Reset mid-stream and pointer wrap:**
  - Push 10, pop 10, repeat 5 times. Entries must be in order and `count` must return to 0 after each pass.
  - Then assert `reset` with 5 entries queued. Next cycle: `out_valid`=0, `count`=0, `ts`=0.
